// File: rtl/shift_seq_ctrl.sv
// Multi-bit shift/rotate sequencer: iterates an external single-step
// combinational shift_rotate stage `count` times over a valid/ready command.
module shift_seq_ctrl #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [2:0]       in_opcode,
    input  logic [CNT_W-1:0] in_count,
    output logic [WIDTH-1:0] sr_a,
    output logic [2:0]       sr_opcode,
    input  logic [WIDTH-1:0] sr_result,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_err,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_work;
    logic [2:0]       r_op;
    logic [CNT_W-1:0] r_cnt;
    logic             r_err;
    logic             w_accept;
    logic             w_illegal;
    logic             w_last_step;

    assign w_accept    = in_valid && (r_state == IDLE);
    assign w_illegal   = in_opcode[2] && in_opcode[1];
    assign w_last_step = (r_cnt == CNT_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (in_valid) begin
                    if (w_illegal || (in_count == '0)) begin
                        w_next = DONE;
                    end else begin
                        w_next = RUN;
                    end
                end
            end
            RUN: begin
                if (w_last_step) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (r_state == IDLE);
        out_valid = (r_state == DONE);
        busy      = (r_state != IDLE);
    end

    // RUN is only entered with a non-zero count, so the decrement never wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_work <= '0;
            r_op   <= '0;
            r_cnt  <= '0;
            r_err  <= 1'b0;
        end else if (w_accept) begin
            r_work <= in_data;
            r_op   <= in_opcode;
            r_cnt  <= in_count;
            r_err  <= w_illegal;
        end else if (r_state == RUN) begin
            r_work <= sr_result;
            r_cnt  <= r_cnt - CNT_W'(1);
        end
    end

    assign sr_a      = r_work;
    assign sr_opcode = r_op;
    assign out_data  = r_work;
    assign out_err   = r_err;

endmodule

// File: doc/shift_seq_ctrl.md
Name: shift_seq_ctrl

Overview:
- Multi-bit shift/rotate sequencer that sits directly upstream of the combinational shift_rotate stage. That stage shifts by one bit per evaluation.
- The sequencer accepts a command {operand, opcode, count} over a valid/ready handshake.
- It drives shift_rotate's a/opcode inputs and feeds shift_rotate's result back into its work register, once per clock, count times.
- It then presents the final value on a valid/ready output.

Parameters:
- WIDTH, 8, operand/result width; must match the shift_rotate instance.
- CNT_W, 3, width of the shift count; maximum shift amount is 2^CNT_W-1.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  command valid.
- in_ready  out  1  command accepted when in_valid & in_ready at a rising edge.
- in_data  in  WIDTH  operand.
- in_opcode  in  3  shift_rotate opcode: 000 SHL, 001 SHR logical, 010 SAR, 011 ROL, 100 ROR, 101 pass; 110/111 illegal.
- in_count  in  CNT_W  number of single-bit steps.
- sr_a  out  WIDTH  to shift_rotate a; always equals the work register.
- sr_opcode  out  3  to shift_rotate opcode; always equals the stored opcode.
- sr_result  in  WIDTH  from shift_rotate result.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer ready.
- out_data  out  WIDTH  final value; equals the work register.
- out_err  out  1  illegal opcode flag; qualified by out_valid.
- busy  out  1  high when state is not IDLE.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE.
  - work, op, cnt, err registers = 0.
  - out_valid=0, busy=0, sr_a=0, sr_opcode=000.
  - in_ready=1 (combinational from IDLE); no capture occurs while rst_n is low.
- States are IDLE, RUN and DONE. in_ready = (state==IDLE). out_valid = (state==DONE).
- IDLE, on an accept edge:
  - Capture work<=in_data, op<=in_opcode, cnt<=in_count.
  - If in_opcode is 110/111: err<=1 and go to DONE; work holds in_data unshifted.
  - Else if in_count==0: err<=0 and go to DONE.
  - Else: err<=0 and go to RUN.
- RUN, each edge:
  - work<=sr_result, cnt<=cnt-1.
  - When cnt==1 at that edge, go to DONE.
  - Exactly in_count steps are performed. in_ready=0 throughout.
- DONE:
  - Hold out_data and out_err stable while out_valid=1 and out_ready=0.
  - On out_valid & out_ready go to IDLE. A new command cannot be accepted on that same edge.
- Latency: out_valid rises in the cycle after edge E0+max(count,1) … precisely:
  - count 0 or illegal opcode: out_valid is high in the cycle immediately after the accept edge.
  - count N>0: out_valid is high after N further edges.
  - Minimum command-to-command period is count+2 cycles, with out_ready tied high.
- shift_rotate is purely combinational; sr_result is sampled in the same cycle sr_a/sr_opcode are driven. No other combinational path exists from inputs to outputs except in_ready and out_valid from state.
- Opcode 101 (pass) with count>0 runs the full count steps and returns the operand unchanged.
- cnt is never decremented below 0; count 2^CNT_W-1 completes with no wrap.
- in_valid asserted while busy is ignored; upstream must hold the command until in_ready.
- Reset mid-RUN or mid-DONE:
  - The pending result is discarded and out_valid drops immediately.
  - After rst_n rises, the block is in IDLE with the work register at 0.

Test Plan:
- Reset then idle: rst_n low for 2 cycles -> out_valid=0, busy=0, in_ready=1, sr_a=0x00.
- in_data=8'b10110101, opcode 011, count 3, out_ready=1 -> busy for 3 RUN cycles; out_data=8'b10101101, out_err=0; out_valid high 1 cycle.
- in_data=8'b10110101, opcode 010, count 2 -> out_data=8'b11101101.
- in_data=8'b10110101, opcode 000, count 7 -> out_data=8'b10000000. Then opcode 100, count 0 -> out_data=8'b10110101 one cycle after accept.
- Illegal opcode 110, in_data=0xB5, count 5 -> out_valid next cycle, out_err=1, out_data=0xB5, no RUN cycles.
- Backpressure and reset:
  - Hold out_ready=0 for 4 cycles in DONE -> out_data stable, in_ready=0.
  - Then assert rst_n=0 mid-RUN of a count-7 command -> out_valid=0 and state IDLE immediately; next command completes correctly.
